// File: rtl/ula_pkg.sv
// Shared constants for the ALU issue/writeback stage: ALU op codes,
// MIPS opcode/funct values and the issue FSM state encoding.
package ula_pkg;

  // ALU operation codes driven onto the ula OP port
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_SLLV = 4'b1110;
  localparam logic [3:0] ALU_SRLV = 4'b1111;

  // MIPS primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct field values
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_decode.sv
// Combinational decode of one MIPS instruction into ALU operands, op code
// and writeback/branch control flags.
module ula_decode
  import ula_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [3:0]  op,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  shamt,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic        is_branch,
  output logic        is_bne,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        writes;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  // Decode table; unsupported encodings fall back to a harmless ADD with no writeback
  always_comb begin
    op        = ALU_ADD;
    in1       = rs_val;
    in2       = rt_val;
    shamt     = 5'd0;
    wb_reg    = 5'd0;
    writes    = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        wb_reg = instr[15:11];
        writes = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: op = ALU_ADD;
          FN_SUB, FN_SUBU: op = ALU_SUB;
          FN_AND:          op = ALU_AND;
          FN_OR:           op = ALU_OR;
          FN_XOR:          op = ALU_XOR;
          FN_NOR:          op = ALU_NOR;
          FN_SLT:          op = ALU_SLT;
          FN_SLL: begin
            op    = ALU_SLL;
            shamt = instr[10:6];
          end
          FN_SRL, FN_SRA: begin
            op    = ALU_SRL;
            shamt = instr[10:6];
          end
          // The ALU shifts by all of In1, so only the low 5 bits of rs may pass
          FN_SLLV: begin
            op  = ALU_SLLV;
            in1 = {27'd0, rs_val[4:0]};
          end
          FN_SRLV, FN_SRAV: begin
            op  = ALU_SRLV;
            in1 = {27'd0, rs_val[4:0]};
          end
          default: begin
            illegal = 1'b1;
            writes  = 1'b0;
            wb_reg  = 5'd0;
          end
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW: begin
        in2    = imm_sext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_SW: begin
        in2    = imm_sext;
        wb_reg = instr[20:16];
      end
      OPC_SLTI: begin
        op     = ALU_SLT;
        in2    = imm_sext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_ANDI: begin
        op     = ALU_AND;
        in2    = imm_zext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_ORI: begin
        op     = ALU_OR;
        in2    = imm_zext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_XORI: begin
        op     = ALU_XOR;
        in2    = imm_zext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_LUI: begin
        op     = ALU_LUI;
        in2    = imm_zext;
        wb_reg = instr[20:16];
        writes = 1'b1;
      end
      OPC_BEQ: begin
        op        = ALU_SUB;
        is_branch = 1'b1;
      end
      OPC_BNE: begin
        op        = ALU_SUB;
        is_branch = 1'b1;
        is_bne    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // $0 is hardwired, so a write to it is suppressed here
  assign wb_en = writes & (wb_reg != 5'd0);

endmodule

// File: rtl/ula_issue.sv
// Issue/writeback stage: accepts a decoded instruction, drives the ula
// operand ports for one cycle of evaluation, then holds the writeback/branch
// record until downstream accepts it.
module ula_issue
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        illegal
);

  state_t      state_reg;
  logic        is_branch_reg;
  logic        is_bne_reg;

  logic [3:0]  dec_op;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  logic [4:0]  dec_shamt;
  logic [4:0]  dec_wb_reg;
  logic        dec_wb_en;
  logic        dec_is_branch;
  logic        dec_is_bne;
  logic        dec_illegal;

  ula_decode u_decode (
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .op        (dec_op),
    .in1       (dec_in1),
    .in2       (dec_in2),
    .shamt     (dec_shamt),
    .wb_reg    (dec_wb_reg),
    .wb_en     (dec_wb_en),
    .is_branch (dec_is_branch),
    .is_bne    (dec_is_bne),
    .illegal   (dec_illegal)
  );

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);

  // Issue FSM; alu_* registers only load on accept so they hold between records
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      alu_op        <= 4'd0;
      alu_in1       <= 32'd0;
      alu_in2       <= 32'd0;
      alu_shamt     <= 5'd0;
      wb_en         <= 1'b0;
      wb_reg        <= 5'd0;
      wb_data       <= 32'd0;
      branch_taken  <= 1'b0;
      illegal       <= 1'b0;
      is_branch_reg <= 1'b0;
      is_bne_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            alu_op        <= dec_op;
            alu_in1       <= dec_in1;
            alu_in2       <= dec_in2;
            alu_shamt     <= dec_shamt;
            wb_en         <= dec_wb_en;
            wb_reg        <= dec_wb_reg;
            illegal       <= dec_illegal;
            is_branch_reg <= dec_is_branch;
            is_bne_reg    <= dec_is_bne;
            state_reg     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wb_data      <= alu_result;
          branch_taken <= is_branch_reg & (alu_zero ^ is_bne_reg);
          state_reg    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue with a behavioural ula model closing the loop.
module tb_ula_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic        illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ula_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .alu_op       (alu_op),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  // Behavioural ula: In1 op In2, shifts act on In2, SLT unsigned
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0011: alu_result = alu_in2 << alu_shamt;
      4'b0101: alu_result = alu_in2 >> alu_shamt;
      4'b0110: alu_result = alu_in1 - alu_in2;
      4'b0111: alu_result = {31'd0, (alu_in1 < alu_in2)};
      4'b1011: alu_result = alu_in2 << 16;
      4'b1100: alu_result = ~(alu_in1 | alu_in2);
      4'b1101: alu_result = alu_in1 ^ alu_in2;
      4'b1110: alu_result = alu_in2 << alu_in1;
      4'b1111: alu_result = alu_in2 >> alu_in1;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        chk_alu;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic        wb_en;
    logic        chk_reg;
    logic [4:0]  wb_reg;
    logic        chk_data;
    logic [31:0] wb_data;
    logic        br;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  // Present one record, check EXEC-cycle operands, DONE record and return to IDLE
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, ".in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    instr    = v.instr;
    rs_val   = v.rs;
    rt_val   = v.rt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({v.name, ".exec_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({v.name, ".exec_in_ready"}, {31'd0, in_ready}, 32'd0);
    if (v.chk_alu) begin
      chk({v.name, ".alu_op"}, {28'd0, alu_op}, {28'd0, v.op});
      chk({v.name, ".alu_in1"}, alu_in1, v.in1);
      chk({v.name, ".alu_in2"}, alu_in2, v.in2);
      chk({v.name, ".alu_shamt"}, {27'd0, alu_shamt}, {27'd0, v.shamt});
    end
    @(posedge clk);
    #1;
    chk({v.name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({v.name, ".wb_en"}, {31'd0, wb_en}, {31'd0, v.wb_en});
    if (v.chk_reg) chk({v.name, ".wb_reg"}, {27'd0, wb_reg}, {27'd0, v.wb_reg});
    if (v.chk_data) chk({v.name, ".wb_data"}, wb_data, v.wb_data);
    chk({v.name, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, v.br});
    chk({v.name, ".illegal"}, {31'd0, illegal}, {31'd0, v.ill});
    $display("txn %s instr=0x%08h wb_en=%0d wb_reg=%0d wb_data=0x%08h br=%0d ill=%0d",
             v.name, v.instr, wb_en, wb_reg, wb_data, branch_taken, illegal);
    @(posedge clk);
    #1;
    chk({v.name, ".back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] held_data;
    logic [31:0] held_in1;
    int          cyc;

    //            name      instr         rs           rt           ca op     in1          in2          sh  we cr reg cd data         br ill
    vecs[0]  = '{"add",    32'h00221820, 32'd5,       32'd7,       1, 4'h2, 32'd5,       32'd7,       0, 1, 1, 3,  1, 32'd12,      0, 0};
    vecs[1]  = '{"addi",   32'h2004FFFF, 32'd0,       32'd0,       1, 4'h2, 32'd0,       32'hFFFFFFFF,0, 1, 1, 4,  1, 32'hFFFFFFFF,0, 0};
    vecs[2]  = '{"lui",    32'h3C051234, 32'd0,       32'd0,       1, 4'hB, 32'd0,       32'h00001234,0, 1, 1, 5,  1, 32'h12340000,0, 0};
    vecs[3]  = '{"sllv",   32'h00223004, 32'h24,      32'd1,       1, 4'hE, 32'd4,       32'd1,       0, 1, 1, 6,  1, 32'h10,      0, 0};
    vecs[4]  = '{"beq",    32'h10220003, 32'd9,       32'd9,       1, 4'h6, 32'd9,       32'd9,       0, 0, 0, 0,  1, 32'd0,       1, 0};
    vecs[5]  = '{"bne",    32'h14220003, 32'd9,       32'd9,       1, 4'h6, 32'd9,       32'd9,       0, 0, 0, 0,  1, 32'd0,       0, 0};
    vecs[6]  = '{"sub",    32'h00223822, 32'd10,      32'd3,       1, 4'h6, 32'd10,      32'd3,       0, 1, 1, 7,  1, 32'd7,       0, 0};
    vecs[7]  = '{"sll",    32'h00024100, 32'h55,      32'd3,       1, 4'h3, 32'h55,      32'd3,       4, 1, 1, 8,  1, 32'h30,      0, 0};
    vecs[8]  = '{"ori",    32'h34298001, 32'h10000000,32'd0,       1, 4'h1, 32'h10000000,32'h00008001,0, 1, 1, 9,  1, 32'h10008001,0, 0};
    vecs[9]  = '{"slti",   32'h282AFFFF, 32'd5,       32'd0,       1, 4'h7, 32'd5,       32'hFFFFFFFF,0, 1, 1, 10, 1, 32'd1,       0, 0};
    vecs[10] = '{"sw",     32'hAC220004, 32'h100,     32'd0,       1, 4'h2, 32'h100,     32'd4,       0, 0, 0, 0,  1, 32'h104,     0, 0};
    vecs[11] = '{"ill_op", 32'hFC000000, 32'd1,       32'd2,       0, 4'h2, 32'd0,       32'd0,       0, 0, 0, 0,  0, 32'd0,       0, 1};
    vecs[12] = '{"add_r0", 32'h00220020, 32'd1,       32'd1,       1, 4'h2, 32'd1,       32'd1,       0, 0, 0, 0,  1, 32'd2,       0, 0};
    vecs[13] = '{"xor",    32'h00225826, 32'h0000F0F0,32'h0000FF00,1, 4'hD, 32'h0000F0F0,32'h0000FF00,0, 1, 1, 11, 1, 32'h00000FF0,0, 0};
    vecs[14] = '{"ill_fn", 32'h00221801, 32'd1,       32'd2,       0, 4'h2, 32'd0,       32'd0,       0, 0, 0, 0,  0, 32'd0,       0, 1};

    // Reset state
    #12;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst.alu_in1", alu_in1, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // alu_* hold the last issued record while idle
    chk("hold.alu_in1_idle", alu_in1, 32'h1);
    chk("hold.alu_in2_idle", alu_in2, 32'h2);

    // Backpressure: stall 5 cycles in DONE while a second record is offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00221820;
    rs_val    = 32'd20;
    rt_val    = 32'd22;
    @(posedge clk);
    #1;
    instr  = 32'h00223822;   // a sub offered while busy must be ignored
    rs_val = 32'd100;
    rt_val = 32'd1;
    @(posedge clk);
    #1;
    held_data = wb_data;
    held_in1  = alu_in1;
    chk("bp.wb_data", held_data, 32'd42);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp.wb_data_stable", wb_data, 32'd42);
      chk("bp.alu_in1_stable", alu_in1, 32'd20);
    end
    $display("txn backpressure wb_data=0x%08h held five cycles", wb_data);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_idle", {30'd0, in_ready, out_valid}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_dup", {30'd0, in_ready, out_valid}, 32'd2);

    // Throughput: accept to next in_ready is three cycles with out_ready high
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 32'h00221820;
    rs_val   = 32'd1;
    rt_val   = 32'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!in_ready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("tput.cycles", cyc, 32'd3);
    $display("txn throughput cycles=%0d", cyc);

    // Asynchronous reset during EXEC drops the record at once
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 32'h00221820;
    rs_val   = 32'd5;
    rt_val   = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rstx.in_exec", {31'd0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstx.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstx.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstx.alu_in1", alu_in1, 32'd0);
    chk("rstx.wb_reg", {27'd0, wb_reg}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstx.held_idle", {30'd0, in_ready, out_valid}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstx.after_release", {30'd0, in_ready, out_valid}, 32'd2);
    $display("txn reset_mid_exec record dropped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
